centroid_update: RTL and testbench
==================================

# centroid_update

Downstream stage of the k-means datapath. Consumes each point's coordinates together with the winning cluster index from the minimum-finder, and accumulates per-cluster coordinate sums and member counts over an epoch. On an epoch-end strobe it divides sum by count for every cluster with a sequential divider, then emits the new centroids one cluster at a time. The emitted centroids feed the centroid registers (x/y centroid stores) for the next epoch.

## Interface
- COORD_W, 32, unsigned coordinate width
- NUM_CLUSTERS, 4, cluster count (index width IDX_W = clog2, 2 at default)
- CNT_W, 16, per-cluster member counter width
- SUM_W, COORD_W+CNT_W (48), accumulator width
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- pt_valid  in  1  point + index valid
- pt_ready  out  1  block accepts a point this cycle
- pt_x, pt_y  in  COORD_W  point coordinates
- pt_idx  in  IDX_W  assigned cluster from min-finder
- epoch_end  in  1  single-cycle strobe: close epoch, start update
- cen_valid  out  1  one-cycle pulse, centroid outputs valid
- cen_idx  out  IDX_W  cluster being emitted
- cen_x, cen_y  out  COORD_W  new centroid
- cen_empty  out  1  cluster had zero members; cen_x/cen_y = 0, consumer keeps old centroid
- busy  out  1  high in any state other than ACCUM
- done  out  1  one-cycle pulse after last centroid emitted
- cnt_ovf  out  1  sticky: a member counter saturated this epoch

## Operation
- States: ACCUM, DIVIDE, EMIT, CLEAR.
- ACCUM: pt_ready=1. On pt_valid: sum_x[pt_idx]+=pt_x, sum_y[pt_idx]+=pt_y, cnt[pt_idx]+=1. Counter at 2^CNT_W-1: point accepted but not accumulated, cnt_ovf set; sums therefore never overflow SUM_W.
- pt_idx >= NUM_CLUSTERS: point accepted and discarded.
- epoch_end in ACCUM: same-cycle point is accumulated first, then k=0 and transition. epoch_end outside ACCUM ignored.
- For cluster k: cnt[k]==0 -> EMIT directly with cen_empty=1. Else DIVIDE: x and y quotients computed in parallel, unsigned restoring division, SUM_W iterations, truncating quotient (low COORD_W bits; quotient provably fits).
- EMIT: cen_valid=1 for one cycle; k<NUM_CLUSTERS-1 -> k+1 and back to DIVIDE/EMIT decision, else CLEAR.
- CLEAR: all sums, counts, cnt_ovf zeroed; done=1; return to ACCUM.
- Reset (any time, incl. mid-DIVIDE): state ACCUM, accumulators/counters/divider zero, all outputs 0 except pt_ready=1; no partial centroid emitted.

## Timing
- Accumulation: point registered on the accepting edge; zero throughput bubbles in ACCUM.
- epoch_end accepted at edge T: busy=1 from T+1.
- Non-empty cluster: DIVIDE occupies SUM_W cycles, EMIT 1 cycle -> SUM_W+1 cycles per cluster. Empty cluster: 1 cycle (EMIT only).
- Defaults, all non-empty: cen_valid at T+49, T+98, T+147, T+196; CLEAR/done at T+197; pt_ready=1 at T+198.
- cen_* outputs registered; hold value between pulses.

## Configuration
- CENTROID_ROUND_EN defined: dividend pre-biased by cnt>>1, giving round-half-up quotient; latency unchanged.
- Undefined: truncating quotient, no bias adder.

## Structure
- Package kmeans_pkg: COORD_W, CNT_W, SUM_W, NUM_CLUSTERS, IDX_W, state enum cu_state_t.
- Sub-module seq_divider (start/done, SUM_W-bit dividend, CNT_W-bit divisor, fixed SUM_W-cycle latency); two instances (x, y).

## Test plan
- Reset mid-DIVIDE of cluster 1 -> no cen_valid, pt_ready=1 next cycle, next epoch's results unaffected by prior data.
- Cluster 0 gets (10,20),(20,40),(31,61) -> cen_idx 0, cen_x=20, cen_y=40 (truncate); with CENTROID_ROUND_EN cen_x=20, cen_y=40; (1,1),(2,2) -> 1 truncated, 2 rounded.
- Only clusters 0 and 2 populated -> clusters 1,3 emit cen_empty=1, cen_x=cen_y=0, one cycle each; total epoch-to-done = 2*49+2+1 cycles.
- Point with pt_valid and epoch_end same cycle to cluster 3, sole member (7,9) -> cluster 3 emits (7,9).
- Max coordinates 0xFFFFFFFF, 3 points to cluster 1 -> cen_x=cen_y=0xFFFFFFFF; counter preset-saturation test -> cnt_ovf=1, extra points ignored, cleared after done.
- epoch_end pulsed during DIVIDE -> ignored; exactly NUM_CLUSTERS cen_valid pulses and one done.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared parameters and types for the k-means centroid update stage.
package kmeans_pkg;

    localparam int unsigned COORD_W      = 32;
    localparam int unsigned NUM_CLUSTERS = 4;
    localparam int unsigned IDX_W        = $clog2(NUM_CLUSTERS);
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned SUM_W        = COORD_W + CNT_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StAccum,
        StDivide,
        StEmit,
        StClear
    } cu_state_t;

    // Min-finder may present an index beyond the configured cluster count.
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < NUM_CLUSTERS;
    endfunction

endpackage

// File: rtl/centroid_update_if.sv
// Point input and centroid output bundle of the centroid update stage.
interface centroid_update_if;
    import kmeans_pkg::*;

    logic               pt_valid;
    logic               pt_ready;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic [IDX_W-1:0]   pt_idx;
    logic               epoch_end;
    logic               cen_valid;
    logic [IDX_W-1:0]   cen_idx;
    logic [COORD_W-1:0] cen_x;
    logic [COORD_W-1:0] cen_y;
    logic               cen_empty;
    logic               busy;
    logic               done;
    logic               cnt_ovf;

    // Upstream datapath / downstream centroid stores side.
    modport master (
        output pt_valid, pt_x, pt_y, pt_idx, epoch_end,
        input  pt_ready, cen_valid, cen_idx, cen_x, cen_y, cen_empty, busy, done, cnt_ovf
    );

    // Centroid update block side.
    modport slave (
        input  pt_valid, pt_x, pt_y, pt_idx, epoch_end,
        output pt_ready, cen_valid, cen_idx, cen_x, cen_y, cen_empty, busy, done, cnt_ovf
    );

endinterface

// File: rtl/centroid_update_seq_divider.sv
// Unsigned restoring divider with a fixed SUM_W-cycle latency.
// The first iteration is folded into the start edge, so done rises
// SUM_W-1 edges after start and the quotient is usable on the SUM_W-th edge.
module seq_divider
    import kmeans_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SUM_W-1:0]   dividend,
    input  logic [CNT_W-1:0]   divisor,
    output logic [COORD_W-1:0] quotient,
    output logic               done
);

    localparam int unsigned ITER_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0]  quo_q, quo_d, quo_src;
    logic [CNT_W-1:0]  rem_q, rem_d, rem_src;
    logic [CNT_W-1:0]  div_q, div_src;
    logic [CNT_W:0]    partial;
    logic [CNT_W-1:0]  diff;
    logic              ge;
    logic [ITER_W-1:0] iter_q, iter_d;

    assign done     = (iter_q == ITER_W'(SUM_W));
    // Quotient never exceeds the largest coordinate, so the low bits suffice.
    assign quotient = quo_q[COORD_W-1:0];

    // One shift-subtract step; operands come from the inputs on the start cycle.
    always_comb begin
        rem_src = start ? '0 : rem_q;
        quo_src = start ? dividend : quo_q;
        div_src = start ? divisor : div_q;
        partial = {rem_src, quo_src[SUM_W-1]};
        ge      = (partial >= {1'b0, div_src});
        // Only used when ge, where the true difference fits in CNT_W bits.
        diff    = partial[CNT_W-1:0] - div_src;
        rem_d   = rem_q;
        quo_d   = quo_q;
        iter_d  = iter_q;
        if (start || (iter_q != '0 && !done)) begin
            rem_d  = ge ? diff : partial[CNT_W-1:0];
            quo_d  = {quo_src[SUM_W-2:0], ge};
            iter_d = start ? ITER_W'(1) : iter_q + 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            iter_q <= '0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_src;
            iter_q <= iter_d;
        end
    end

endmodule

// File: rtl/centroid_update.sv
// k-means centroid update: accumulates per-cluster sums/counts over an epoch,
// then divides and emits one centroid per cluster.
// Optional feature macro: CENTROID_ROUND_EN (round-half-up quotient).
module centroid_update
    import kmeans_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    centroid_update_if.slave bus
);

    cu_state_t state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;

    logic [SUM_W-1:0] sum_x_q [NUM_CLUSTERS];
    logic [SUM_W-1:0] sum_y_q [NUM_CLUSTERS];
    logic [CNT_W-1:0] cnt_q   [NUM_CLUSTERS];
    logic [SUM_W-1:0] sum_x_d [NUM_CLUSTERS];
    logic [SUM_W-1:0] sum_y_d [NUM_CLUSTERS];
    logic [CNT_W-1:0] cnt_d   [NUM_CLUSTERS];
    logic             ovf_q, ovf_d;

    logic               decide;
    logic               div_start;
    logic               emit_load;
    logic               emit_empty;
    logic [SUM_W-1:0]   dividend_x, dividend_y;
    logic [CNT_W-1:0]   divisor;
    logic [COORD_W-1:0] quo_x, quo_y;
    logic               done_x, done_y;

    logic [IDX_W-1:0]   cen_idx_q;
    logic [COORD_W-1:0] cen_x_q, cen_y_q;
    logic               cen_empty_q;

    // Accumulate accepted points; a saturated counter drops the point and flags overflow.
    always_comb begin
        for (int i = 0; i < int'(NUM_CLUSTERS); i++) begin
            sum_x_d[i] = sum_x_q[i];
            sum_y_d[i] = sum_y_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        ovf_d = ovf_q;
        if (state_q == StAccum && bus.pt_valid && idx_in_range(bus.pt_idx)) begin
            if (cnt_q[bus.pt_idx] == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                sum_x_d[bus.pt_idx] = sum_x_q[bus.pt_idx] + SUM_W'(bus.pt_x);
                sum_y_d[bus.pt_idx] = sum_y_q[bus.pt_idx] + SUM_W'(bus.pt_y);
                cnt_d[bus.pt_idx]   = cnt_q[bus.pt_idx] + 1'b1;
            end
        end
        if (state_q == StClear) begin
            for (int i = 0; i < int'(NUM_CLUSTERS); i++) begin
                sum_x_d[i] = '0;
                sum_y_d[i] = '0;
                cnt_d[i]   = '0;
            end
            ovf_d = 1'b0;
        end
    end

    // Epoch sequencing; 'decide' picks divide or direct empty emit for cluster k_d.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        decide     = 1'b0;
        div_start  = 1'b0;
        emit_load  = 1'b0;
        emit_empty = 1'b0;
        unique case (state_q)
            StAccum: begin
                if (bus.epoch_end) begin
                    k_d    = '0;
                    decide = 1'b1;
                end
            end
            StDivide: begin
                if (done_x && done_y) begin
                    state_d   = StEmit;
                    emit_load = 1'b1;
                end
            end
            StEmit: begin
                if (k_q == IDX_W'(NUM_CLUSTERS - 1)) begin
                    state_d = StClear;
                end else begin
                    k_d    = k_q + 1'b1;
                    decide = 1'b1;
                end
            end
            StClear: begin
                state_d = StAccum;
            end
        endcase
        if (decide) begin
            if (cnt_d[k_d] == '0) begin
                state_d    = StEmit;
                emit_load  = 1'b1;
                emit_empty = 1'b1;
            end else begin
                state_d   = StDivide;
                div_start = 1'b1;
            end
        end
    end

    // Divider operands; the *_d view includes a point accepted alongside epoch_end.
`ifdef CENTROID_ROUND_EN
    logic [SUM_W-1:0] bias;
    always_comb begin
        bias       = SUM_W'(cnt_d[k_d] >> 1);
        dividend_x = sum_x_d[k_d] + bias;
        dividend_y = sum_y_d[k_d] + bias;
        divisor    = cnt_d[k_d];
    end
`else
    always_comb begin
        dividend_x = sum_x_d[k_d];
        dividend_y = sum_y_d[k_d];
        divisor    = cnt_d[k_d];
    end
`endif

    seq_divider u_div_x (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend_x),
        .divisor  (divisor),
        .quotient (quo_x),
        .done     (done_x)
    );

    seq_divider u_div_y (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend_y),
        .divisor  (divisor),
        .quotient (quo_y),
        .done     (done_y)
    );

    // State, accumulators and registered centroid outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StAccum;
            k_q         <= '0;
            ovf_q       <= 1'b0;
            cen_idx_q   <= '0;
            cen_x_q     <= '0;
            cen_y_q     <= '0;
            cen_empty_q <= 1'b0;
            for (int i = 0; i < int'(NUM_CLUSTERS); i++) begin
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < int'(NUM_CLUSTERS); i++) begin
                sum_x_q[i] <= sum_x_d[i];
                sum_y_q[i] <= sum_y_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            if (emit_load) begin
                cen_idx_q   <= k_d;
                cen_x_q     <= emit_empty ? '0 : quo_x;
                cen_y_q     <= emit_empty ? '0 : quo_y;
                cen_empty_q <= emit_empty;
            end
        end
    end

    assign bus.pt_ready  = (state_q == StAccum);
    assign bus.busy      = (state_q != StAccum);
    assign bus.cen_valid = (state_q == StEmit);
    assign bus.done      = (state_q == StClear);
    assign bus.cen_idx   = cen_idx_q;
    assign bus.cen_x     = cen_x_q;
    assign bus.cen_y     = cen_y_q;
    assign bus.cen_empty = cen_empty_q;
    assign bus.cnt_ovf   = ovf_q;

endmodule

// File: tb/tb_centroid_update.sv
// Scoreboard bench for centroid_update: random and directed epochs against a
// sum/count/mean reference model with cycle-accurate emit timing.
`timescale 1ns/1ps
module tb_centroid_update;
    import kmeans_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    centroid_update_if bus_if();

    centroid_update dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              idx;
        longint unsigned x;
        longint unsigned y;
        bit              empty;
        int              at;
    } cen_t;

    cen_t exp_cen[$];
    int   exp_done[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   epoch_cyc   = 0;

    // Reference model: plain per-cluster sums, counts and an overflow flag.
    longint unsigned m_sx [NUM_CLUSTERS];
    longint unsigned m_sy [NUM_CLUSTERS];
    longint unsigned m_cnt[NUM_CLUSTERS];
    bit              m_ovf;
    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 1;

    function automatic void chk(string name, longint unsigned act, longint unsigned want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(NUM_CLUSTERS); i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
    endfunction

    function automatic void model_point(longint unsigned x, longint unsigned y, int idx);
        if (idx >= int'(NUM_CLUSTERS)) return;
        if (m_cnt[idx] == CNT_LIMIT) begin
            m_ovf = 1'b1;
        end else begin
            m_sx[idx] += x; m_sy[idx] += y; m_cnt[idx] += 1;
        end
    endfunction

    function automatic longint unsigned mean(longint unsigned s, longint unsigned c);
`ifdef CENTROID_ROUND_EN
        return (s + c / 2) / c;
`else
        return s / c;
`endif
    endfunction

    // Closing at edge t: cluster k appears after its cumulative cost (SUM_W+1 or 1 cycles).
    function automatic void model_close(int t);
        int n = 0;
        for (int k = 0; k < int'(NUM_CLUSTERS); k++) begin
            cen_t e;
            e.idx = k;
            if (m_cnt[k] == 0) begin
                n += 1;
                e.x = 0; e.y = 0; e.empty = 1'b1;
            end else begin
                n += int'(SUM_W) + 1;
                e.x = mean(m_sx[k], m_cnt[k]);
                e.y = mean(m_sy[k], m_cnt[k]);
                e.empty = 1'b0;
            end
            e.at = t + n - 1;
            exp_cen.push_back(e);
        end
        exp_done.push_back(t + n);
        model_clear();
    endfunction

    // Monitor: every centroid pulse and done pulse is matched against the queues.
    cen_t mon_e;
    int   mon_d;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.cen_valid) begin
                if (exp_cen.size() == 0) begin
                    chk("unexpected cen_valid", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_cen.pop_front();
                    chk("cen_idx",   64'(bus_if.cen_idx),   64'(mon_e.idx));
                    chk("cen_x",     64'(bus_if.cen_x),     mon_e.x);
                    chk("cen_y",     64'(bus_if.cen_y),     mon_e.y);
                    chk("cen_empty", 64'(bus_if.cen_empty), 64'(mon_e.empty));
                    chk("cen cycle", 64'(cyc),              64'(mon_e.at));
                end
            end
            if (bus_if.done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected done", 64'(1), 64'(0));
                end else begin
                    mon_d = exp_done.pop_front();
                    chk("done cycle", 64'(cyc), 64'(mon_d));
                end
            end
        end
    end

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic drive(input bit v, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                         input logic [IDX_W-1:0] idx, input bit eoe);
        bus_if.pt_valid  = v;
        bus_if.pt_x      = x;
        bus_if.pt_y      = y;
        bus_if.pt_idx    = idx;
        bus_if.epoch_end = eoe;
        if (v) chk("pt_ready in accum", 64'(bus_if.pt_ready), 64'(1));
        @(posedge clk);
        #1;
        if (v) model_point(64'(x), 64'(y), int'(idx));
        if (eoe) begin
            chk("cnt_ovf at close", 64'(bus_if.cnt_ovf), 64'(m_ovf));
            epoch_cyc = cyc;
            model_close(cyc);
            chk("busy after epoch_end", 64'(bus_if.busy), 64'(1));
            chk("pt_ready after epoch_end", 64'(bus_if.pt_ready), 64'(0));
        end
        bus_if.pt_valid  = 1'b0;
        bus_if.epoch_end = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (bus_if.done) seen = 1'b1;
        end
        if (!seen) chk("done timeout", 64'(0), 64'(1));
        @(negedge clk);
        chk("pt_ready after done",  64'(bus_if.pt_ready),  64'(1));
        chk("busy after done",      64'(bus_if.busy),      64'(0));
        chk("cnt_ovf after done",   64'(bus_if.cnt_ovf),   64'(0));
        chk("pending centroids",    64'(exp_cen.size()),   64'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst pt_ready",  64'(bus_if.pt_ready),  64'(1));
        chk("rst busy",      64'(bus_if.busy),      64'(0));
        chk("rst cen_valid", 64'(bus_if.cen_valid), 64'(0));
        chk("rst done",      64'(bus_if.done),      64'(0));
        chk("rst cnt_ovf",   64'(bus_if.cnt_ovf),   64'(0));
        chk("rst cen_x",     64'(bus_if.cen_x),     64'(0));
        chk("rst cen_y",     64'(bus_if.cen_y),     64'(0));
        chk("rst cen_idx",   64'(bus_if.cen_idx),   64'(0));
        chk("rst cen_empty", 64'(bus_if.cen_empty), 64'(0));
    endtask

    task automatic random_epoch(input int npts);
        int unsigned mask = $urandom_range(1, 15);
        logic [IDX_W-1:0] idx;
        for (int i = 0; i < npts; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, '0, '0, '0, 1'b0);
            do idx = IDX_W'($urandom_range(0, NUM_CLUSTERS - 1)); while (!mask[idx]);
            drive(1'b1, $urandom, $urandom, idx, 1'b0);
        end
        do idx = IDX_W'($urandom_range(0, NUM_CLUSTERS - 1)); while (!mask[idx]);
        if ($urandom_range(0, 1) == 1) drive(1'b1, $urandom, $urandom, idx, 1'b1);
        else                           drive(1'b0, '0, '0, '0, 1'b1);
        wait_done();
    endtask

    initial begin
        int n;
        bus_if.pt_valid  = 1'b0;
        bus_if.pt_x      = '0;
        bus_if.pt_y      = '0;
        bus_if.pt_idx    = '0;
        bus_if.epoch_end = 1'b0;
        model_clear();

        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-DIVIDE of cluster 1: nothing for cluster 1 may appear.
        drive(1'b1, 32'd100, 32'd200, 2'd0, 1'b0);
        drive(1'b1, 32'd555, 32'd777, 2'd1, 1'b0);
        drive(1'b1, 32'd333, 32'd999, 2'd1, 1'b1);
        n = 0;
        while (cyc < epoch_cyc + int'(SUM_W) + 11 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset = 1'b1;
        exp_cen.delete();
        exp_done.delete();
        model_clear();
        #1 chk_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("pt_ready after reset", 64'(bus_if.pt_ready), 64'(1));
        chk("busy after reset",     64'(bus_if.busy),      64'(0));
        repeat (60) @(negedge clk);

        // Mean values for cluster 0 and rounding-sensitive cluster 1.
        drive(1'b1, 32'd10, 32'd20, 2'd0, 1'b0);
        drive(1'b1, 32'd20, 32'd40, 2'd0, 1'b0);
        drive(1'b1, 32'd31, 32'd61, 2'd0, 1'b0);
        drive(1'b1, 32'd1,  32'd1,  2'd1, 1'b0);
        drive(1'b1, 32'd2,  32'd2,  2'd1, 1'b0);
        drive(1'b1, 32'd4000, 32'd5, 2'd2, 1'b1);
        wait_done();

        // Only clusters 0 and 2 populated.
        drive(1'b1, 32'd8, 32'd16, 2'd0, 1'b0);
        drive(1'b1, 32'd9, 32'd17, 2'd2, 1'b0);
        drive(1'b1, 32'd12, 32'd3, 2'd2, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1);
        wait_done();

        // Sole member of cluster 3 arrives with the epoch_end strobe.
        drive(1'b1, $urandom, $urandom, 2'd0, 1'b0);
        drive(1'b1, $urandom, $urandom, 2'd1, 1'b0);
        drive(1'b1, 32'd7, 32'd9, 2'd3, 1'b1);
        wait_done();

        // Maximum coordinates, plus epoch_end pulsed while dividing.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 1'b0);
        drive(1'b1, 32'd50, 32'd60, 2'd0, 1'b1);
        repeat (20) @(negedge clk);
        bus_if.epoch_end = 1'b1;
        @(negedge clk);
        bus_if.epoch_end = 1'b0;
        wait_done();

        // Random epochs, including same-cycle close and empty clusters.
        for (int e = 0; e < 6; e++) random_epoch(int'($urandom_range(1, 40)));

        // Counter saturation on cluster 2: last two points must be dropped.
        for (int i = 0; i < int'(CNT_LIMIT) + 2; i++)
            drive(1'b1, $urandom, $urandom, 2'd2, 1'b0);
        drive(1'b1, 32'd42, 32'd43, 2'd0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1);
        wait_done();

        // Epoch after saturation starts from clean counters.
        random_epoch(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
